// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port
//   of imem_loader.
//
//   in_valid / in_data / in_ready : byte stream into the loader
//   mem_we / mem_addr / mem_wdata  : one-cycle word writes to the memory
//
//   Modports:
//     slave  - the loader (consumes the stream, drives the memory port)
//     master - the environment (drives the stream, observes writes)
// ---------------------------------------------------------------------------
interface imem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction memory writer. It takes a byte stream made of a
//   16-bit big-endian word count N followed by N big-endian 32-bit words.
//   Each word is written to byte address 4*k. The processor is held in reset
//   until the whole image has been written.
//
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
//   byte equal to the XOR of all data bytes. On a mismatch the load ends in
//   ERR.
//
//   Ports:
//     clk      system clock (rising edge)
//     rst      synchronous active-high reset
//     start    one-cycle load request (honoured in IDLE/DONE/ERR)
//     bus      imem_loader_if.slave: byte stream in, memory write port out
//     cpu_rst  processor reset, high while not successfully loaded
//     busy     load in progress (including a final write still in flight)
//     done     image loaded, level until next start/rst
//     err      load aborted, level until next start/rst
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH_WORDS = 256,
   parameter int CNT_W       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_rst,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   // Where the load goes once the header or data phase is complete.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_TAIL = CHK;
`else
   localparam state_t ST_TAIL = DONE;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;    // words accepted so far
   logic [1:0]       bidx_q, bidx_d;    // byte position within the word
   logic [23:0]      word_q, word_d;    // upper three bytes; byte 3 goes straight out
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       csum_q, csum_d;
`endif

   logic             rdy;
   logic             acc;
   logic [15:0]      n_hdr;
   logic [CNT_W-1:0] wcnt_inc;

   always_comb begin
      rdy = 1'b0;
      case (state_q)
         LEN_HI, LEN_LO, DATA: rdy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK:                  rdy = 1'b1;
`endif
         default:              rdy = 1'b0;
      endcase
   end

   assign acc      = rdy & bus.in_valid;
   assign n_hdr    = {len_q[7:0], bus.in_data};
   assign wcnt_inc = wcnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_HI;
               wcnt_d  = '0;
               bidx_d  = '0;
               word_d  = '0;
               addr_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         LEN_HI: begin
            if (acc) begin
               len_d   = CNT_W'(bus.in_data);
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (acc) begin
               len_d = CNT_W'(n_hdr);
               if (32'(n_hdr) > 32'(DEPTH_WORDS)) state_d = ERR;
               else if (n_hdr == 16'd0)           state_d = ST_TAIL;
               else                               state_d = DATA;
            end
         end
         DATA: begin
            if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.in_data;
`endif
               bidx_d = bidx_q + 2'd1;
               case (bidx_q)
                  2'd0: word_d[23:16] = bus.in_data;
                  2'd1: word_d[15:8]  = bus.in_data;
                  2'd2: word_d[7:0]   = bus.in_data;
                  default: begin
                     // Word complete: the write is registered and issued
                     // next cycle, so the following byte can be accepted now.
                     we_d    = 1'b1;
                     wdata_d = {word_q, bus.in_data};
                     addr_d  = 32'({wcnt_q, 2'b00});
                     wcnt_d  = wcnt_inc;
                     if (wcnt_inc == len_q) state_d = ST_TAIL;
                  end
               endcase
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: begin
            if (acc) state_d = (bus.in_data == csum_q) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // DONE is entered in the same cycle as the final write pulse. Gating with
   // we_q delays done/cpu_rst release by one cycle, so the processor never
   // leaves reset while a write is still outstanding.
   assign done    = (state_q == DONE) && !we_q;
   assign cpu_rst = !done;
   assign err     = (state_q == ERR);
   assign busy    = rdy || we_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the processor fetches from.
- Receives a byte stream on a valid/ready interface, assembles big-endian 32-bit instruction words, and writes them at consecutive word-aligned byte addresses starting at 0.
- Holds the processor in reset for the whole load and releases it only after a complete, legal image has been written.

Parameters:
- DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; images longer than this are rejected.
- CNT_W, 16, width of the word-count header field and of the internal word counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  byte address of the write; always a multiple of 4.
- mem_wdata  output  32  instruction word.
- cpu_rst  output  1  reset to the processor; high = held in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded successfully; level, held until the next start or rst.
- err  output  1  load aborted; level, held until the next start or rst.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, done=0, err=0. State is IDLE; the byte counter and word counter are 0.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK (present only with the optional feature), DONE, ERR.
- IDLE, on start:
  - go to LEN_HI; busy=1, cpu_rst=1, done=0, err=0.
  - clear the word counter, byte index and write address.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CHK, and 0 elsewhere. There is no backpressure from memory; the write port accepts a write every cycle.
- LEN_HI: the accepted byte becomes N[15:8]; go to LEN_LO.
- LEN_LO: the accepted byte becomes N[7:0]. Next state:
  - N > DEPTH_WORDS: go to ERR.
  - N == 0: go to CHK if the feature is compiled in, otherwise DONE.
  - otherwise: go to DATA.
- DATA, byte assembly:
  - Bytes arrive MSB first; byte index 0..3 fills bits [31:24], [23:16], [15:8], [7:0].
  - The cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_wdata = the assembled word, mem_addr = 4*k, where k is the word index starting at 0.
  - The byte index then wraps to 0.
- Write pipelining: the next byte may be accepted in the same cycle as the mem_we pulse, giving back-to-back words at 1 byte/cycle.
- Leaving DATA: after word N-1 is accepted, move to CHK or DONE. The final mem_we is still issued in the following cycle.
- done and cpu_rst timing:
  - done=1 and cpu_rst=0 assert on the same cycle, no earlier than the cycle after the final mem_we.
  - The processor therefore never leaves reset with a write outstanding.
- DONE:
  - busy=0, done=1, cpu_rst=0.
  - A new start re-enters LEN_HI, asserts cpu_rst=1 and clears done.
- ERR:
  - busy=0, err=1, cpu_rst=1; remaining stream bytes are not accepted.
  - Only start or rst leaves ERR.
- start while busy is ignored.
- rst mid-load:
  - immediately return to reset values; the partial word is discarded.
  - no further mem_we; cpu_rst remains 1.
- in_valid=0 mid-word stalls with no timeout; the assembled bytes are held.
- Address arithmetic: mem_addr = {word_index, 2'b00}, zero-extended to 32 bits. The word index never exceeds DEPTH_WORDS-1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Compiled in:
  - After the last data word (or directly after LEN_LO when N=0), the CHK state accepts one byte.
  - The expected value is the XOR of every data byte (header excluded).
  - Match: go to DONE.
  - Mismatch: go to ERR; cpu_rst stays 1. Words already written remain in memory.
- Compiled out: the CHK state does not exist, and no trailing byte is consumed.

Test Plan:
- Reset then start, stream 00 02 | 20 01 00 05 | 08 00 00 00, continuous valid:
  - mem_we pulses at addr 0x0 with data 0x20010005, then at addr 0x4 with data 0x08000000.
  - done=1 and cpu_rst=0 on the cycle after the second write.
- Same image with in_valid toggled 1/0 every cycle: identical writes and values; no mem_we occurs before the 4th byte of each word.
- Header 00 00: no mem_we; done=1 and cpu_rst=0 (with the feature, only after checksum byte 00).
- With DEPTH_WORDS=256, header 01 01 (N=257): ERR on the cycle after LEN_LO, in_ready=0, cpu_rst=1, no mem_we.
- rst asserted after 2 data bytes of word 1, then start with a fresh 1-word image 00 01 AA BB CC DD:
  - a single write at addr 0x0 with data 0xAABBCCDD; nothing from the aborted load appears.
- Feature on, image 00 01 12 34 56 78:
  - trailing byte 0x08 gives done=1.
  - trailing byte 0x09 gives err=1 and cpu_rst=1, with the word still written at 0x0.
